karatsuba_pipe: RTL and testbench

KARATSUBA_PIPE -- requirements
Module: karatsuba_pipe

---
 rtl/karatsuba_pipe.sv | 129 ++++++++++++
 tb/tb_karatsuba_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_pipe.sv
// Three-stage pipelined Karatsuba multiplier with valid/ready flow control and a sideband tag.
// Defining KARATSUBA_SIGNED_EN selects two's complement operands and result; otherwise unsigned.
module karatsuba_pipe #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
) (
    input  logic                 clkn_i,
    input  logic                 rstn_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 busy_o
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    logic v1, v2, v3;
    logic adv1, adv2, take_in;

    // A stage moves forward when the stage after it is empty or itself moving forward.
    assign adv2       = v2 && (!v3 || out_ready_i);
    assign adv1       = v1 && (!v2 || adv2);
    assign in_ready_o = !v1 || adv1;
    assign take_in    = in_valid_i && in_ready_o;

    assign out_valid_o = v3;
    assign busy_o      = v1 || v2 || v3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (take_in)                v1 <= 1'b1;
            else if (adv1)              v1 <= 1'b0;
            if (adv1)                   v2 <= 1'b1;
            else if (adv2)              v2 <= 1'b0;
            if (adv2)                   v3 <= 1'b1;
            else if (v3 && out_ready_i) v3 <= 1'b0;
        end
    end

    // Operand magnitudes entering S1.
    logic [WIDTH-1:0] ua, ub;
    logic             sign_in;
`ifdef KARATSUBA_SIGNED_EN
    // Negating the most negative value wraps to itself, which is the correct magnitude unsigned.
    assign ua      = a_i[WIDTH-1] ? -a_i : a_i;
    assign ub      = b_i[WIDTH-1] ? -b_i : b_i;
    assign sign_in = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`else
    assign ua      = a_i;
    assign ub      = b_i;
    assign sign_in = 1'b0;
`endif

    // S1: halves and pre-sums.
    logic [H-1:0]     s1_ah, s1_al, s1_bh, s1_bl;
    logic [H:0]       s1_as, s1_bs;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_sign;

    // NOTE: datapath registers are not reset; the valid flags alone decide whether their contents matter.
    always_ff @(posedge clkn_i) begin
        if (take_in) begin
            s1_ah   <= ua[WIDTH-1:H];
            s1_al   <= ua[H-1:0];
            s1_bh   <= ub[WIDTH-1:H];
            s1_bl   <= ub[H-1:0];
            s1_as   <= {1'b0, ua[WIDTH-1:H]} + {1'b0, ua[H-1:0]};
            s1_bs   <= {1'b0, ub[WIDTH-1:H]} + {1'b0, ub[H-1:0]};
            s1_tag  <= tag_i;
            s1_sign <= sign_in;
        end
    end

    // S2: the three sub-products.
    logic [2*H-1:0]   s2_pl, s2_ph;
    logic [2*H+1:0]   s2_pm;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_sign;

    always_ff @(posedge clkn_i) begin
        if (adv1) begin
            s2_pl   <= {{H{1'b0}}, s1_al} * {{H{1'b0}}, s1_bl};
            s2_ph   <= {{H{1'b0}}, s1_ah} * {{H{1'b0}}, s1_bh};
            s2_pm   <= {{(H+1){1'b0}}, s1_as} * {{(H+1){1'b0}}, s1_bs};
            s2_tag  <= s1_tag;
            s2_sign <= s1_sign;
        end
    end

    // S3 recombination; mid cannot underflow because Pm >= Ph + Pl.
    logic [2*H+1:0] mid;
    logic [PW-1:0]  uprod, result;

    assign mid   = s2_pm - {2'b00, s2_ph} - {2'b00, s2_pl};
    assign uprod = {s2_ph, {WIDTH{1'b0}}}
                 + ({{(PW-2*H-2){1'b0}}, mid} << H)
                 + {{WIDTH{1'b0}}, s2_pl};
`ifdef KARATSUBA_SIGNED_EN
    assign result = s2_sign ? -uprod : uprod;
`else
    assign result = uprod;
`endif

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            product_o <= '0;
            tag_o     <= '0;
        end else if (adv2) begin
            product_o <= result;
            tag_o     <= s2_tag;
        end
    end

`ifndef KARATSUBA_SIGNED_EN
    logic unused_sign;
    assign unused_sign = s2_sign;
`endif
endmodule

// File: tb/tb_karatsuba_pipe.sv
// Directed self-checking bench for karatsuba_pipe (WIDTH=24, TAG_W=4); follows KARATSUBA_SIGNED_EN if defined.
module tb_karatsuba_pipe;
    localparam int WIDTH = 24;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [TAG_W-1:0]   tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] product;
    logic [TAG_W-1:0]   tag_out;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    karatsuba_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clkn_i      (clk),
        .rstn_i      (rstn),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .tag_o       (tag_out),
        .busy_o      (busy)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (product !== 48'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
        checks++; if (tag_out !== 4'h0) begin failures++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_unsigned_max();
        logic [2*WIDTH-1:0] exp_p;
`ifdef KARATSUBA_SIGNED_EN
        exp_p = 48'h000000000001;
`else
        exp_p = 48'hFFFFFE000001;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; a = 24'hFFFFFF; b = 24'hFFFFFF; tag = 4'h5;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL max_first_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL max_valid_edge1 got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL max_valid_edge2 got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL max_valid_edge3 got=%b exp=1", out_valid); end
        checks++; if (product !== exp_p) begin failures++; $display("FAIL max_product got=%h exp=%h", product, exp_p); end
        checks++; if (tag_out !== 4'h5) begin failures++; $display("FAIL max_tag got=%h exp=5", tag_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL max_drained got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL max_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0]   av [3];
        logic [WIDTH-1:0]   bv [3];
        logic [2*WIDTH-1:0] ev [3];
        av = '{24'h000003, 24'h001000, 24'hABCDEF};
        bv = '{24'h000007, 24'h001000, 24'h000001};
`ifdef KARATSUBA_SIGNED_EN
        ev = '{48'h15, 48'h1000000, 48'hFFFFFFABCDEF};
`else
        ev = '{48'h15, 48'h1000000, 48'hABCDEF};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = av[i]; b = bv[i]; tag = 4'(i + 8);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid%0d got=%b exp=1", k, out_valid); end
            checks++; if (product !== ev[k]) begin failures++; $display("FAIL stream_product%0d got=%h exp=%h", k, product, ev[k]); end
            checks++; if (tag_out !== 4'(k + 8)) begin failures++; $display("FAIL stream_tag%0d got=%h exp=%h", k, tag_out, 4'(k + 8)); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0]   av [4];
        logic [WIDTH-1:0]   bv [4];
        logic [2*WIDTH-1:0] ev [4];
        int                 acc;
        logic               rdy;
        av = '{24'h000002, 24'h000100, 24'h123456, 24'h7FFFFF};
        bv = '{24'h000003, 24'h000100, 24'h000010, 24'h000002};
        ev = '{48'h6, 48'h10000, 48'h1234560, 48'hFFFFFE};
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; a = av[acc]; b = bv[acc]; tag = 4'(acc + 1);
            rdy = in_ready;
            tick();
            if (rdy) acc++;
        end
        checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", acc); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
        for (int s = 0; s < 3; s++) begin
            checks++; if (out_valid !== 1'b1 || product !== ev[0] || tag_out !== 4'h1) begin
                failures++; $display("FAIL bp_stall%0d got=%b/%h/%h exp=1/%h/1", s, out_valid, product, tag_out, ev[0]);
            end
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) tick();
            checks++; if (out_valid !== 1'b1 || product !== ev[k] || tag_out !== 4'(k + 1)) begin
                failures++; $display("FAIL bp_drain%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, product, tag_out, ev[k], 4'(k + 1));
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b/%b exp=0/0", out_valid, busy); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 24'h000011 + 24'(i); b = 24'h000022; tag = 4'hA;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || product === 48'h0) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/nonzero", out_valid, product); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_async_flags got=%b/%b/%b exp=0/0/1", out_valid, busy, in_ready);
        end
        checks++; if (product !== 48'h0 || tag_out !== 4'h0) begin failures++; $display("FAIL mid_async_data got=%h/%h exp=0/0", product, tag_out); end
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost%0d got=%b exp=0", c, out_valid); end
        end
    endtask

`ifdef KARATSUBA_SIGNED_EN
    task automatic test_signed();
        logic [WIDTH-1:0]   av [3];
        logic [WIDTH-1:0]   bv [3];
        logic [2*WIDTH-1:0] ev [3];
        av = '{24'h800000, 24'hFFFFFD, 24'hFFFFFF};
        bv = '{24'h800000, 24'h000005, 24'hFFFFFF};
        ev = '{48'h400000000000, 48'hFFFFFFFFFFF1, 48'h000000000001};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = av[i]; b = bv[i]; tag = 4'(i + 2);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            checks++; if (out_valid !== 1'b1 || product !== ev[k] || tag_out !== 4'(k + 2)) begin
                failures++; $display("FAIL signed%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, product, tag_out, ev[k], 4'(k + 2));
            end
        end
        tick();
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_unsigned_max();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef KARATSUBA_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
